fifo_flow_ctrl: RTL and testbench

Parametrised synchronous FIFO with per-entry data, exact full/empty detection and programmable-threshold flow control. It is the next generation of the channel FIFO. Depth and width are generic, and a pointer extra-bit scheme makes full depth usable. Pause/continua are driven by a hysteresis state machine, and overflow/underflow are reported as distinct sticky errors. It sits between the upstream producer, which obeys `pause`, and the downstream arbiter, which issues `pop`.

---
 rtl/fifo_flow_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fifo_flow_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flow_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_flow_ctrl
//   Synchronous FIFO with exact full/empty detection and watermark-based flow
//   control. It sits between an upstream producer that obeys `pause` and a
//   downstream arbiter that issues `pop`.
//
//   Pointers carry one extra wrap bit, so all DEPTH entries are usable and
//   occupancy is simply wr_ptr - rd_ptr. A two-state hysteresis machine
//   (RUN/PAUSED) drives pause/continua. Overflow and underflow are reported
//   as separate sticky flags.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   push/data_in  write request and write data
//   pop           read request
//   umbral_alto   high watermark: RUN -> PAUSED when count >= umbral_alto
//   umbral_bajo   low watermark:  PAUSED -> RUN when count <= umbral_bajo
//   clr_error     synchronous clear of overflow/underflow (a new event wins)
//   data_out      registered read data, held when no pop is accepted
//   valid_out     one-cycle strobe per accepted pop
//   count         occupancy 0..DEPTH
//   empty/full/almost_full/almost_empty   combinational status from count
//   pause/continua                        registered flow-control state
//   overflow/underflow/fifo_error         sticky error flags
// -----------------------------------------------------------------------------
module fifo_flow_ctrl #(
  parameter int BUS_SIZE   = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BUS_SIZE-1:0]   data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  clr_error,
  output logic [BUS_SIZE-1:0]   data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pause,
  output logic                  continua,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  fifo_error
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } fc_state_t;

  logic [BUS_SIZE-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                pop_acc;
  logic                push_acc;
  logic                overflow_evt;
  logic                underflow_evt;
  fc_state_t           state_q;
  fc_state_t           state_d;

  // Occupancy and status, combinational from the registered pointers.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign almost_full  = (count >= umbral_alto);
  assign almost_empty = (count <= umbral_bajo);

  // A pop on a full FIFO frees a slot in the same edge, so the push is taken too.
  // A pop on an empty FIFO is never accepted: there is no fall-through.
  assign pop_acc       = pop & ~empty;
  assign push_acc      = push & (~full | pop_acc);
  assign overflow_evt  = push & full & ~pop_acc;
  assign underflow_evt = pop & empty;

  // NOTE: the storage array has no reset; every entry is written before it can
  // be read, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  // NOTE: all registered state uses non-blocking assignments so every
  // always_ff block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // Sticky errors: setting takes priority over a simultaneous clear, so an
  // event in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_evt) begin
        overflow <= 1'b1;
      end else if (clr_error) begin
        overflow <= 1'b0;
      end
      if (underflow_evt) begin
        underflow <= 1'b1;
      end else if (clr_error) begin
        underflow <= 1'b0;
      end
    end
  end

  assign fifo_error = overflow | underflow;

  // Flow-control hysteresis, evaluated on the current count. With
  // umbral_bajo >= umbral_alto both exits can be true and the state toggles
  // every cycle; that is accepted behaviour for such a configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (count >= umbral_alto) state_d = PAUSED;
      PAUSED:  if (count <= umbral_bajo) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign pause    = (state_q == PAUSED);
  assign continua = ~pause;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_flow_ctrl
//   Self-checking bench for fifo_flow_ctrl (BUS_SIZE=6, ADDR_WIDTH=3).
//   Inputs are driven on the falling edge and outputs are sampled 1 ns after
//   the rising edge. A queue holds the words expected from the FIFO: a word
//   is appended when its push is accepted and removed/compared when the pop
//   that reads it completes. Flags and the flow-control state come from a
//   small behavioural model of occupancy, hysteresis and sticky errors.
// -----------------------------------------------------------------------------
module tb_fifo_flow_ctrl;

  localparam int BUS_SIZE   = 6;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                clk = 1'b0;
  logic                reset;
  logic                push;
  logic                pop;
  logic [BUS_SIZE-1:0] data_in;
  logic [ADDR_WIDTH:0] umbral_alto;
  logic [ADDR_WIDTH:0] umbral_bajo;
  logic                clr_error;
  logic [BUS_SIZE-1:0] data_out;
  logic                valid_out;
  logic [ADDR_WIDTH:0] count;
  logic                empty, full, almost_full, almost_empty;
  logic                pause, continua;
  logic                overflow, underflow, fifo_error;

  fifo_flow_ctrl #(.BUS_SIZE(BUS_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .clr_error    (clr_error),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause),
    .continua     (continua),
    .overflow     (overflow),
    .underflow    (underflow),
    .fifo_error   (fifo_error)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model state.
  logic [BUS_SIZE-1:0] m_q[$];
  logic [BUS_SIZE-1:0] m_last;
  logic                m_pause;
  logic                m_ov;
  logic                m_un;
  int                  n_vec = 0;
  int                  n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model; exp_valid is the accepted-pop
  // result of the edge just taken.
  task automatic check_outputs(input logic exp_valid);
    int          c;
    logic [8:0]  got_st;
    logic [8:0]  exp_st;
    c      = m_q.size();
    got_st = {empty, full, almost_full, almost_empty, pause, continua,
              overflow, underflow, fifo_error};
    exp_st = {c == 0, c == DEPTH, c >= int'(umbral_alto), c <= int'(umbral_bajo),
              m_pause, ~m_pause, m_ov, m_un, m_ov | m_un};
    check("count",  32'(count), 32'(c));
    check("status", 32'(got_st), 32'(exp_st));
    check("valid",  32'(valid_out), 32'(exp_valid));
    check("data",   32'(data_out), 32'(m_last));
  endtask

  // One clock cycle of stimulus plus the model update and checks.
  task automatic step(input logic p, input logic q, input logic [BUS_SIZE-1:0] d,
                      input logic clr = 1'b0);
    int   c;
    logic pa, pu, ov_e, un_e;
    @(negedge clk);
    push      = p;
    pop       = q;
    data_in   = d;
    clr_error = clr;
    c    = m_q.size();
    pa   = q && (c > 0);
    pu   = p && ((c < DEPTH) || pa);
    ov_e = p && (c == DEPTH) && !pa;
    un_e = q && (c == 0);
    if (!m_pause && (c >= int'(umbral_alto)))     m_pause = 1'b1;
    else if (m_pause && (c <= int'(umbral_bajo))) m_pause = 1'b0;
    @(posedge clk);
    #1;
    if (pa) m_last = m_q.pop_front();
    if (pu) m_q.push_back(d);
    m_ov = ov_e | (m_ov & ~clr);
    m_un = un_e | (m_un & ~clr);
    check_outputs(pa);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_pause = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  logic prev_pause;

  initial begin
    reset       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    data_in     = '0;
    clr_error   = 1'b0;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;
    model_reset();
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Fill with 0x01..0x08, then drain in order.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 6'(i));
    check("full_after_8", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
    check("empty_at_end", 32'(empty), 32'd1);

    // Overflow: a 9th push is dropped, then the flags are cleared.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 6'(8'h20 + i));
    step(1'b1, 1'b0, 6'h3F);
    check("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("ovf_clear", 32'(fifo_error), 32'd0);
    // Clear and a new overflow in the same edge: the set wins.
    step(1'b1, 1'b0, 6'h3E, 1'b1);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Full with simultaneous push+pop, then 20 cycles of push+pop for wrap.
    step(1'b1, 1'b1, 6'h2A);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 6'($urandom_range(0, 63)));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

    // Pop on empty with a push of 0x15: underflow, no fall-through.
    step(1'b1, 1'b1, 6'h15);
    check("unf_set", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, '0, 1'b1);
    check("unf_pop_data", 32'(data_out), 32'h15);

    // Hysteresis with alto=6, bajo=2: up to 6, down to 2, then idle once.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 6'(i + 8'h30));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    check("pause_released", 32'(pause), 32'd0);

    // Misconfigured thresholds (bajo >= alto): the state toggles every cycle.
    umbral_alto = 4'd1;
    umbral_bajo = 4'd5;
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      prev_pause = pause;
      step(1'b0, 1'b0, '0);
      check("toggle", 32'(prev_pause ^ pause), 32'd1);
    end
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

    // Build count=5 with pause=1, then reset asynchronously mid-cycle.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 6'(i + 8'h10));
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    check("pre_reset_count", 32'(count), 32'd5);
    check("pre_reset_pause", 32'(pause), 32'd1);
    #2;
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b1;

    // After reset the FIFO works from a clean state.
    step(1'b1, 1'b0, 6'h05);
    step(1'b0, 1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
